// File: rtl/block_sprite_arbiter_if.sv
// Request/grant, sprite-table lookup and response bundle for block_sprite_arbiter.
// master: renderers plus sprite table; slave: the arbiter.
interface block_sprite_arbiter_if #(
   parameter int unsigned OFF_W = 8
);
   logic             req_a;
   logic             req_b;
   logic [2:0]       type_a;
   logic [2:0]       type_b;
   logic [OFF_W-1:0] xoff_a;
   logic [OFF_W-1:0] yoff_a;
   logic [OFF_W-1:0] xoff_b;
   logic [OFF_W-1:0] yoff_b;
   logic             gnt_a;
   logic             gnt_b;
   logic [2:0]       spr_sel;
   logic [1:0]       spr_row;
   logic [1:0]       spr_col;
   logic [3:0]       spr_pix;
   logic             rsp_valid;
   logic             rsp_id;
   logic [3:0]       rsp_color;

   modport master (
      output req_a, req_b, type_a, type_b, xoff_a, yoff_a, xoff_b, yoff_b, spr_pix,
      input  gnt_a, gnt_b, spr_sel, spr_row, spr_col, rsp_valid, rsp_id, rsp_color
   );

   modport slave (
      input  req_a, req_b, type_a, type_b, xoff_a, yoff_a, xoff_b, yoff_b, spr_pix,
      output gnt_a, gnt_b, spr_sel, spr_row, spr_col, rsp_valid, rsp_id, rsp_color
   );
endinterface

// File: rtl/block_sprite_arbiter.sv
// Round-robin share of the block sprite lookup between playfield (A) and preview (B) renderers,
// two-cycle fixed latency. BLOCK_SPRITE_ARB_STATS_EN adds grant/conflict counters.
module block_sprite_arbiter #(
   parameter int unsigned SCALE_SHIFT = 2,
   parameter int unsigned OFF_W       = 8
) (
   input  logic                    clk,
   input  logic                    rst,
`ifdef BLOCK_SPRITE_ARB_STATS_EN
   input  logic                    stats_clr,
   output logic [15:0]             gnt_cnt_a,
   output logic [15:0]             gnt_cnt_b,
   output logic [15:0]             conflict_cnt,
`endif
   block_sprite_arbiter_if.slave   bus
);

   typedef enum logic {GntA = 1'b0, GntB = 1'b1} gnt_e;

   gnt_e       last_gnt_q, last_gnt_d;
   logic       gnt_a, gnt_b, grant;
   logic [2:0] sel_type;
   logic [1:0] sel_row, sel_col;

   logic [2:0] spr_sel_q;
   logic [1:0] spr_row_q, spr_col_q;
   logic       s1_valid_q, s1_id_q, s1_none_q;
   logic       rsp_valid_q, rsp_id_q;
   logic [3:0] rsp_color_q;

   // Grants are suppressed while reset is held so nothing is accepted then.
   always_comb begin
      gnt_a      = 1'b0;
      gnt_b      = 1'b0;
      last_gnt_d = last_gnt_q;
      if (!rst) begin
         if (bus.req_a && (!bus.req_b || last_gnt_q == GntB)) begin
            gnt_a = 1'b1;
         end else if (bus.req_b) begin
            gnt_b = 1'b1;
         end
      end
      if (gnt_a) begin
         last_gnt_d = GntA;
      end else if (gnt_b) begin
         last_gnt_d = GntB;
      end
   end

   assign grant = gnt_a | gnt_b;

   // Offsets past one block wrap modulo four cells.
   always_comb begin
      sel_type = bus.type_a;
      sel_row  = 2'(bus.yoff_a >> SCALE_SHIFT);
      sel_col  = 2'(bus.xoff_a >> SCALE_SHIFT);
      if (gnt_b) begin
         sel_type = bus.type_b;
         sel_row  = 2'(bus.yoff_b >> SCALE_SHIFT);
         sel_col  = 2'(bus.xoff_b >> SCALE_SHIFT);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt_q  <= GntB;
         spr_sel_q   <= 3'd0;
         spr_row_q   <= 2'd0;
         spr_col_q   <= 2'd0;
         s1_valid_q  <= 1'b0;
         s1_id_q     <= 1'b0;
         s1_none_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_color_q <= 4'd0;
      end else begin
         last_gnt_q <= last_gnt_d;
         s1_valid_q <= grant;
         if (grant) begin
            spr_sel_q <= sel_type;
            spr_row_q <= sel_row;
            spr_col_q <= sel_col;
            s1_id_q   <= gnt_b;
            s1_none_q <= (sel_type == 3'd7);
         end
         rsp_valid_q <= s1_valid_q;
         rsp_id_q    <= s1_id_q;
         rsp_color_q <= s1_none_q ? 4'd0 : bus.spr_pix;
      end
   end

   assign bus.gnt_a     = gnt_a;
   assign bus.gnt_b     = gnt_b;
   assign bus.spr_sel   = spr_sel_q;
   assign bus.spr_row   = spr_row_q;
   assign bus.spr_col   = spr_col_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_color = rsp_color_q;

`ifdef BLOCK_SPRITE_ARB_STATS_EN
   logic [15:0] gnt_cnt_a_q, gnt_cnt_b_q, conflict_cnt_q;

   // Clear wins over a same-cycle increment; counters stick at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_cnt_a_q    <= 16'd0;
         gnt_cnt_b_q    <= 16'd0;
         conflict_cnt_q <= 16'd0;
      end else if (stats_clr) begin
         gnt_cnt_a_q    <= 16'd0;
         gnt_cnt_b_q    <= 16'd0;
         conflict_cnt_q <= 16'd0;
      end else begin
         if (gnt_a && gnt_cnt_a_q != 16'hFFFF) gnt_cnt_a_q <= gnt_cnt_a_q + 16'd1;
         if (gnt_b && gnt_cnt_b_q != 16'hFFFF) gnt_cnt_b_q <= gnt_cnt_b_q + 16'd1;
         if (bus.req_a && bus.req_b && conflict_cnt_q != 16'hFFFF) begin
            conflict_cnt_q <= conflict_cnt_q + 16'd1;
         end
      end
   end

   assign gnt_cnt_a    = gnt_cnt_a_q;
   assign gnt_cnt_b    = gnt_cnt_b_q;
   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_block_sprite_arbiter.sv
// Directed self-checking bench for block_sprite_arbiter with a small sprite-table model.
// Exercises the stats counters when BLOCK_SPRITE_ARB_STATS_EN is defined.
module tb_block_sprite_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

`ifdef BLOCK_SPRITE_ARB_STATS_EN
   logic        stats_clr = 1'b0;
   logic [15:0] gnt_cnt_a, gnt_cnt_b, conflict_cnt;
`endif

   block_sprite_arbiter_if #(.OFF_W(8)) bus ();

   block_sprite_arbiter #(
      .SCALE_SHIFT(2),
      .OFF_W      (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
`ifdef BLOCK_SPRITE_ARB_STATS_EN
      .stats_clr   (stats_clr),
      .gnt_cnt_a   (gnt_cnt_a),
      .gnt_cnt_b   (gnt_cnt_b),
      .conflict_cnt(conflict_cnt),
`endif
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // Centre 2x2 cells carry a per-piece colour, the border ring uses 4 + type.
   function automatic logic [3:0] sprite_pix(input logic [2:0] sel, input logic [1:0] row,
                                             input logic [1:0] col);
      logic [3:0] c;
      if ((row == 2'd1 || row == 2'd2) && (col == 2'd1 || col == 2'd2)) begin
         case (sel)
            3'd0:    c = 4'd1;
            3'd1:    c = 4'd2;
            3'd2:    c = 4'd3;
            3'd3:    c = 4'd8;
            3'd4:    c = 4'd5;
            3'd5:    c = 4'd6;
            3'd6:    c = 4'd9;
            default: c = 4'd15;
         endcase
      end else begin
         c = 4'd4 + {1'b0, sel};
      end
      return c;
   endfunction

   always_comb bus.spr_pix = sprite_pix(bus.spr_sel, bus.spr_row, bus.spr_col);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.req_a  = 1'b0;
      bus.req_b  = 1'b0;
      bus.type_a = 3'd0;
      bus.type_b = 3'd0;
      bus.xoff_a = 8'd0;
      bus.yoff_a = 8'd0;
      bus.xoff_b = 8'd0;
      bus.yoff_b = 8'd0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_gnt_a", 32'(bus.gnt_a), 0);
      check("rst_gnt_b", 32'(bus.gnt_b), 0);
      check("rst_spr_sel", 32'(bus.spr_sel), 0);
      check("rst_spr_row", 32'(bus.spr_row), 0);
      check("rst_spr_col", 32'(bus.spr_col), 0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_id", 32'(bus.rsp_id), 0);
      check("rst_rsp_color", 32'(bus.rsp_color), 0);
      bus.req_a = 1'b1;
      #1;
      check("rst_req_no_gnt", 32'(bus.gnt_a), 0);

      // Single A lookup: I piece at (5,5) -> cell (1,1)
      next_cycle();
      rst = 1'b0;
      bus.type_a = 3'd0;
      bus.xoff_a = 8'd5;
      bus.yoff_a = 8'd5;
      @(negedge clk);
      check("t1_gnt_a", 32'(bus.gnt_a), 1);
      check("t1_gnt_b", 32'(bus.gnt_b), 0);
      next_cycle();
      bus.req_a = 1'b0;
      @(negedge clk);
      check("t1_spr_sel", 32'(bus.spr_sel), 0);
      check("t1_spr_row", 32'(bus.spr_row), 1);
      check("t1_spr_col", 32'(bus.spr_col), 1);
      check("t1_early_valid", 32'(bus.rsp_valid), 0);
      next_cycle();
      @(negedge clk);
      check("t1_rsp_valid", 32'(bus.rsp_valid), 1);
      check("t1_rsp_id", 32'(bus.rsp_id), 0);
      check("t1_rsp_color", 32'(bus.rsp_color), 1);
      next_cycle();
      @(negedge clk);
      check("t1_rsp_drop", 32'(bus.rsp_valid), 0);

      // B lookups: T border (0,0) then offset 20 wraps to cell (1,1)
      next_cycle();
      bus.req_b  = 1'b1;
      bus.type_b = 3'd3;
      @(negedge clk);
      check("t3_gnt_b0", 32'(bus.gnt_b), 1);
      check("t3_gnt_a0", 32'(bus.gnt_a), 0);
      next_cycle();
      bus.xoff_b = 8'd20;
      bus.yoff_b = 8'd20;
      @(negedge clk);
      check("t3_gnt_b1", 32'(bus.gnt_b), 1);
      check("t3_spr_sel", 32'(bus.spr_sel), 3);
      check("t3_spr_row0", 32'(bus.spr_row), 0);
      check("t3_spr_col0", 32'(bus.spr_col), 0);
      next_cycle();
      bus.req_b = 1'b0;
      @(negedge clk);
      check("t3_rsp_valid0", 32'(bus.rsp_valid), 1);
      check("t3_rsp_id0", 32'(bus.rsp_id), 1);
      check("t3_rsp_color0", 32'(bus.rsp_color), 7);
      check("t3_spr_row1", 32'(bus.spr_row), 1);
      check("t3_spr_col1", 32'(bus.spr_col), 1);
      next_cycle();
      @(negedge clk);
      check("t3_rsp_valid1", 32'(bus.rsp_valid), 1);
      check("t3_rsp_id1", 32'(bus.rsp_id), 1);
      check("t3_rsp_color1", 32'(bus.rsp_color), 8);

      // Conflict for 6 cycles: A (O border, colour 5) and B (J centre, colour 3) alternate
      bus.type_a = 3'd1;
      bus.xoff_a = 8'd0;
      bus.yoff_a = 8'd0;
      bus.type_b = 3'd2;
      bus.xoff_b = 8'd4;
      bus.yoff_b = 8'd4;
      for (int i = 0; i < 9; i++) begin
         next_cycle();
         bus.req_a = (i < 6);
         bus.req_b = (i < 6);
         @(negedge clk);
         check($sformatf("t2_gnt_a_%0d", i), 32'(bus.gnt_a), 32'((i < 6) && (i % 2 == 0)));
         check($sformatf("t2_gnt_b_%0d", i), 32'(bus.gnt_b), 32'((i < 6) && (i % 2 == 1)));
         check($sformatf("t2_excl_%0d", i), 32'(bus.gnt_a & bus.gnt_b), 0);
         check($sformatf("t2_rsp_valid_%0d", i), 32'(bus.rsp_valid), 32'((i >= 2) && (i < 8)));
         if (i >= 2 && i < 8) begin
            check($sformatf("t2_rsp_id_%0d", i), 32'(bus.rsp_id), 32'((i - 2) % 2));
            check($sformatf("t2_rsp_color_%0d", i), 32'(bus.rsp_color),
                  ((i - 2) % 2 == 1) ? 32'd3 : 32'd5);
         end
      end

      // Type 7 forces colour 0, then an O centre lookup back to back
      next_cycle();
      bus.req_a  = 1'b1;
      bus.type_a = 3'd7;
      bus.xoff_a = 8'd5;
      bus.yoff_a = 8'd5;
      @(negedge clk);
      check("t4_gnt_a0", 32'(bus.gnt_a), 1);
      next_cycle();
      bus.type_a = 3'd1;
      bus.xoff_a = 8'd4;
      bus.yoff_a = 8'd8;
      @(negedge clk);
      check("t4_gnt_a1", 32'(bus.gnt_a), 1);
      check("t4_spr_sel7", 32'(bus.spr_sel), 7);
      next_cycle();
      bus.req_a = 1'b0;
      @(negedge clk);
      check("t4_rsp_valid0", 32'(bus.rsp_valid), 1);
      check("t4_rsp_color0", 32'(bus.rsp_color), 0);
      check("t4_spr_row", 32'(bus.spr_row), 2);
      check("t4_spr_col", 32'(bus.spr_col), 1);
      next_cycle();
      @(negedge clk);
      check("t4_rsp_valid1", 32'(bus.rsp_valid), 1);
      check("t4_rsp_color1", 32'(bus.rsp_color), 2);

      // Reset one cycle after a grant discards the in-flight lookup
      next_cycle();
      bus.req_a  = 1'b1;
      bus.type_a = 3'd4;
      bus.xoff_a = 8'd5;
      bus.yoff_a = 8'd5;
      @(negedge clk);
      check("t5_gnt_a", 32'(bus.gnt_a), 1);
      next_cycle();
      bus.req_a = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("t5_spr_sel", 32'(bus.spr_sel), 0);
      check("t5_spr_row", 32'(bus.spr_row), 0);
      check("t5_spr_col", 32'(bus.spr_col), 0);
      check("t5_rsp_valid", 32'(bus.rsp_valid), 0);
      next_cycle();
      bus.req_a = 1'b1;
      bus.req_b = 1'b1;
      @(negedge clk);
      check("t5_gnt_a_in_rst", 32'(bus.gnt_a), 0);
      check("t5_gnt_b_in_rst", 32'(bus.gnt_b), 0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("t5_post_gnt_a", 32'(bus.gnt_a), 1);
      check("t5_post_gnt_b", 32'(bus.gnt_b), 0);
      check("t5_post_valid0", 32'(bus.rsp_valid), 0);
      next_cycle();
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
      @(negedge clk);
      check("t5_post_valid1", 32'(bus.rsp_valid), 0);
      next_cycle();
      @(negedge clk);
      check("t5_post_valid2", 32'(bus.rsp_valid), 1);
      check("t5_post_id", 32'(bus.rsp_id), 0);
      check("t5_post_color", 32'(bus.rsp_color), 5);

`ifdef BLOCK_SPRITE_ARB_STATS_EN
      // Sole B first so the conflicts start with A
      next_cycle();
      bus.req_b = 1'b1;
      next_cycle();
      bus.req_b = 1'b0;
      stats_clr = 1'b1;
      next_cycle();
      stats_clr = 1'b0;
      bus.req_a = 1'b1;
      bus.req_b = 1'b1;
      repeat (2) next_cycle();
      next_cycle();
      bus.req_b = 1'b0;
      repeat (1) next_cycle();
      next_cycle();
      bus.req_a = 1'b0;
      @(negedge clk);
      check("st_gnt_cnt_a", 32'(gnt_cnt_a), 4);
      check("st_gnt_cnt_b", 32'(gnt_cnt_b), 1);
      check("st_conflict_cnt", 32'(conflict_cnt), 3);
      next_cycle();
      stats_clr = 1'b1;
      bus.req_a = 1'b1;
      next_cycle();
      stats_clr = 1'b0;
      bus.req_a = 1'b0;
      @(negedge clk);
      check("st_clr_a", 32'(gnt_cnt_a), 0);
      check("st_clr_b", 32'(gnt_cnt_b), 0);
      check("st_clr_conflict", 32'(conflict_cnt), 0);
`endif

      next_cycle();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/block_sprite_arbiter.md
# block_sprite_arbiter

- Shares the single unit-block sprite lookup port (seven 4x4 tetromino cell patterns, 4-bit colour indices) between two pixel requesters: the playfield renderer (A) and the next-piece preview renderer (B).
- Each cycle it accepts at most one request by round-robin, converts the pixel offset to a sprite row/column, and drives the lookup.
- It returns the colour index with a fixed two-cycle latency.
- It sits between the colour mapper's renderers and the combinational sprite table mux.

## Interface
Parameters:
- SCALE_SHIFT, default 2: log2 of screen pixels per sprite cell; sprite row = y_off >> SCALE_SHIFT, col = x_off >> SCALE_SHIFT.
- OFF_W, default 8: width of the pixel offset inputs.

Ports:
- Clk  in  1  single clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- req_a / req_b  in  1  request from requester A / B; held with fields stable until granted.
- type_a / type_b  in  3  piece type: 0=I, 1=O, 2=J, 3=T, 4=L, 5=S, 6=Z, 7=none.
- xoff_a, yoff_a / xoff_b, yoff_b  in  OFF_W  pixel offset within the block.
- gnt_a / gnt_b  out  1  single-cycle, combinational acceptance strobe in the request's cycle.
- spr_sel  out  3  registered piece select to the sprite table mux.
- spr_row, spr_col  out  2  registered cell coordinates to the sprite table mux.
- spr_pix  in  4  colour index from the sprite table, combinational on spr_sel/row/col.
- rsp_valid  out  1  result strobe.
- rsp_id  out  1  0=A, 1=B.
- rsp_color  out  4  colour index result.

## Operation
- Arbitration:
  - Exactly one of req_a/req_b high: that requester is granted.
  - Both high: grant the requester not granted last (last_gnt register).
  - last_gnt resets to B, so A wins the first conflict.
  - last_gnt updates only on a grant; idle cycles do not change it.
- gnt_a and gnt_b are never high together. A grant is a completed transfer: the requester may change fields or drop req the next cycle.
- Row/column computation: (off >> SCALE_SHIFT) truncated to the low 2 bits, so offsets beyond one block wrap modulo 4 cells.
- Stage 1 register, loaded on grant:
  - spr_sel, spr_row, spr_col, s1_valid, s1_id, s1_none (type==7).
  - With no grant, s1_valid=0 and the spr_* outputs hold their previous values.
- Stage 2 register: loads rsp_valid=s1_valid, rsp_id=s1_id, rsp_color = s1_none ? 0 : spr_pix.
  - Type 7 still occupies a slot and produces rsp_valid with colour 0.
- No backpressure: the renderers must consume rsp_valid the cycle it is asserted.
- Reset values: gnt_a=gnt_b=0 (no requests in reset), spr_sel=0, spr_row=0, spr_col=0, rsp_valid=0, rsp_id=0, rsp_color=0, last_gnt=B, all valid bits 0.

## Timing
- Request in cycle N with gnt high in N: spr_* valid in N+1, rsp_valid/rsp_color in N+2.
- Fixed latency of 2 cycles. Throughput is one lookup per cycle.
- A sole continuous requester is granted every cycle.
- Two continuous requesters alternate A,B,A,B; a waiting requester waits at most one cycle.
- Responses leave in grant order; no reordering.
- Reset asserted mid-operation:
  - In-flight stage-1/stage-2 entries are discarded, with no rsp_valid for them after release.
  - The first grant after release follows reset priority (A on conflict).
- Reset release is synchronised externally; the block does not resynchronise.

## Configuration
- BLOCK_SPRITE_ARB_STATS_EN defined:
  - Adds outputs gnt_cnt_a[15:0], gnt_cnt_b[15:0] (grants per requester) and conflict_cnt[15:0] (cycles with both req high).
  - All counters saturate at 16'hFFFF and reset to 0.
  - Adds input stats_clr (synchronous clear; takes priority over same-cycle increment).
- Undefined: these ports and the counter logic do not exist; all other behaviour is identical.

## Test plan
- Reset, then req_a=1, type_a=0 (I), xoff_a=5, yoff_a=5, SCALE_SHIFT=2 -> gnt_a same cycle; spr_sel=0, row=1, col=1 next cycle; rsp_valid=1, rsp_id=0, rsp_color=1 two cycles after grant.
- req_a and req_b both held high for 6 cycles -> grants A,B,A,B,A,B; responses 2 cycles later with rsp_id 0,1,0,1,0,1; gnt_a and gnt_b never simultaneously high.
- req_b=1, type_b=3 (T), xoff_b=0, yoff_b=0 -> rsp_color=7 (border); same with xoff_b=yoff_b=20 (wrap to cell 1,1) -> rsp_color=8.
- type_a=7 request -> rsp_valid=1 with rsp_color=0; back-to-back with a type 1 (O) centre lookup next cycle -> colours 0 then 2 on consecutive cycles.
- Reset asserted one cycle after a grant -> all outputs 0 immediately, no rsp_valid after release; next conflicting request grants A.
- With BLOCK_SPRITE_ARB_STATS_EN: 3 conflict cycles plus 2 sole-A cycles -> gnt_cnt_a=4, gnt_cnt_b=1, conflict_cnt=3; then stats_clr -> all 0 next cycle.
